if_stage: RTL and testbench

//  Instruction-fetch stage of the pipelined CPU, directly upstream of the instruction ROM.
//  - Holds the PC and drives the word address into the 64-entry ROM.
//  - Captures the returned instruction into the IF/ID pipeline register.
//  - Selects the next PC from PC+4, branch target or jump target (resolved in ID).
//  - Implements the load-use stall from ID and the flush on taken control transfers.

---
 rtl/if_stage.sv | 104 ++++++++++
 tb/tb_if_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM word addressing, IF/ID pipeline register.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 6,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              Stall,
    input  logic [1:0]        Pcsource,
    input  logic [31:0]       Br_Addr,
    input  logic [31:0]       Jmp_Addr,
    input  logic [31:0]       Rom_Inst,
    output logic [ROM_AW-1:0] Rom_Addr,
    output logic [31:0]       If_Pc,
    output logic [31:0]       Id_Inst,
    output logic [31:0]       Id_Pc4,
    output logic              Id_Valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       Fetch_Cnt,
    output logic [31:0]       Stall_Cnt,
    output logic [31:0]       Flush_Cnt
`endif
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{inst: NOP_INST, pc4: 32'h0, valid: 1'b0};

    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] target;
    logic        redirect;
    ifid_t       ifid;

    assign pc4      = pc + 32'd4;
    assign Rom_Addr = pc[ROM_AW+1:2];
    assign If_Pc    = pc;
    assign Id_Inst  = ifid.inst;
    assign Id_Pc4   = ifid.pc4;
    assign Id_Valid = ifid.valid;

    // Reserved encoding 11 falls through to sequential fetch.
    always_comb begin
        redirect = 1'b0;
        target   = Br_Addr;
        case (Pcsource)
            2'b01:   begin redirect = 1'b1; target = Br_Addr;  end
            2'b10:   begin redirect = 1'b1; target = Jmp_Addr; end
            default: ;
        endcase
    end

    // Stall is tested first so an unresolved Pcsource never reaches the PC.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            pc   <= RESET_PC & WORD_MASK;
            ifid <= IFID_BUBBLE;
        end else if (!Stall) begin
            if (redirect) begin
                pc   <= target & WORD_MASK;
                ifid <= IFID_BUBBLE;
            end else begin
                pc   <= pc4;
                ifid <= '{inst: Rom_Inst, pc4: pc4, valid: 1'b1};
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt, flush_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (Stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end else if (redirect) begin
            flush_cnt <= sat_inc(flush_cnt);
        end else begin
            fetch_cnt <= sat_inc(fetch_cnt);
        end
    end

    assign Fetch_Cnt = fetch_cnt;
    assign Stall_Cnt = stall_cnt;
    assign Flush_Cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, redirect, wrap and async reset.
module tb_if_stage;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic        Stall;
    logic [1:0]  Pcsource;
    logic [31:0] Br_Addr, Jmp_Addr, Rom_Inst;
    logic [5:0]  Rom_Addr;
    logic [31:0] If_Pc, Id_Inst, Id_Pc4;
    logic        Id_Valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] Fetch_Cnt, Stall_Cnt, Flush_Cnt;
`endif

    logic [31:0] rom [64];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    assign Rom_Inst = rom[Rom_Addr];

    if_stage dut (
        .Clk(Clk), .Clrn(Clrn), .Stall(Stall), .Pcsource(Pcsource),
        .Br_Addr(Br_Addr), .Jmp_Addr(Jmp_Addr), .Rom_Inst(Rom_Inst),
        .Rom_Addr(Rom_Addr), .If_Pc(If_Pc), .Id_Inst(Id_Inst),
        .Id_Pc4(Id_Pc4), .Id_Valid(Id_Valid)
`ifdef IF_PERF_CNT_EN
        , .Fetch_Cnt(Fetch_Cnt), .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic [31:0] pc4, input logic vld);
        chk({tag, ".pc"},    If_Pc, pc);
        chk({tag, ".inst"},  Id_Inst, inst);
        chk({tag, ".pc4"},   Id_Pc4, pc4);
        chk({tag, ".valid"}, {31'b0, Id_Valid}, {31'b0, vld});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = {16'hC0DE, 16'(i)};
        rom[1] = 32'h00100c22;

        Clrn = 1'b0; Stall = 1'b0; Pcsource = 2'b00;
        Br_Addr = '0; Jmp_Addr = '0;
        #12;
        chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rst.addr", {26'b0, Rom_Addr}, 32'd0);
        @(negedge Clk);
        Clrn = 1'b1;

        // 1: sequential fetch
        step(); chk_ifid("s1.e1", 32'h4, rom[0], 32'h4, 1'b1);
        chk("s1.e1.addr", {26'b0, Rom_Addr}, 32'd1);
        step(); chk_ifid("s1.e2", 32'h8, 32'h00100c22, 32'h8, 1'b1);
        chk("s1.e2.addr", {26'b0, Rom_Addr}, 32'd2);
        step(); chk("s1.e3.addr", {26'b0, Rom_Addr}, 32'd3);
        step(); step(); chk_ifid("s2.pre", 32'h14, rom[4], 32'h14, 1'b1);

        // 2: stall two cycles
        Stall = 1'b1;
        step(); chk_ifid("s2.st1", 32'h14, rom[4], 32'h14, 1'b1);
        step(); chk_ifid("s2.st2", 32'h14, rom[4], 32'h14, 1'b1);
        Stall = 1'b0;
        step(); chk_ifid("s2.go", 32'h18, rom[5], 32'h18, 1'b1);

        // 3: taken branch flushes, then resumes at target
        Pcsource = 2'b01; Br_Addr = 32'h20;
        step(); chk_ifid("s3.br", 32'h20, 32'h0, 32'h0, 1'b0);
        Pcsource = 2'b00;
        step(); chk_ifid("s3.seq", 32'h24, rom[8], 32'h24, 1'b1);

        // 4: jump held off by stall
        Pcsource = 2'b10; Jmp_Addr = 32'h28; Stall = 1'b1;
        step(); chk_ifid("s4.st", 32'h24, rom[8], 32'h24, 1'b1);
        Stall = 1'b0;
        step(); chk_ifid("s4.jmp", 32'h28, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
        chk("cnt.fetch", Fetch_Cnt, 32'd7);
        chk("cnt.stall", Stall_Cnt, 32'd3);
        chk("cnt.flush", Flush_Cnt, 32'd2);
`endif
        Pcsource = 2'bxx; Stall = 1'b1;
        step(); chk("s4.xstall", If_Pc, 32'h28);
        Stall = 1'b0;

        // back-to-back redirects, then reserved encoding acts as sequential
        Pcsource = 2'b01; Br_Addr = 32'h40;
        step(); chk_ifid("b2b.1", 32'h40, 32'h0, 32'h0, 1'b0);
        Pcsource = 2'b10; Jmp_Addr = 32'h33;
        step(); chk_ifid("b2b.2", 32'h30, 32'h0, 32'h0, 1'b0);
        Pcsource = 2'b11;
        step(); chk_ifid("rsv", 32'h34, rom[12], 32'h34, 1'b1);

        // 5: ROM address wrap and unaligned target
        Pcsource = 2'b01; Br_Addr = 32'hFC;
        step(); chk("s5.addr63", {26'b0, Rom_Addr}, 32'd63);
        Pcsource = 2'b00;
        step(); chk_ifid("s5.wrap", 32'h100, rom[63], 32'h100, 1'b1);
        chk("s5.addr0", {26'b0, Rom_Addr}, 32'd0);
        Pcsource = 2'b01; Br_Addr = 32'h23;
        step(); chk("s5.unal", If_Pc, 32'h20);
        Pcsource = 2'b10; Jmp_Addr = 32'hFFFF_FFFF;
        step(); chk("s5.top", If_Pc, 32'hFFFF_FFFC);
        Pcsource = 2'b00;
        step(); chk_ifid("s5.pcwrap", 32'h0, rom[63], 32'h0, 1'b1);

        // 6: async reset mid-cycle with a redirect pending
        step(); step();
        Pcsource = 2'b01; Br_Addr = 32'h80;
        @(negedge Clk);
        #2 Clrn = 1'b0;
        #1 chk_ifid("s6.rst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
        chk("s6.fetch", Fetch_Cnt, 32'd0);
        chk("s6.stall", Stall_Cnt, 32'd0);
        chk("s6.flush", Flush_Cnt, 32'd0);
`endif
        step(); chk("s6.hold", If_Pc, 32'h0);
        @(negedge Clk);
        Clrn = 1'b1; Pcsource = 2'b00;
        step(); chk_ifid("s6.rel", 32'h4, rom[0], 32'h4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
